// File: rtl/flag_stack_br_unit.sv
//==============================================================================
// Module   : flag_stack_br_unit
// Purpose  : Flag register with per-bit masked writes, a LIFO flag stack for
//            save/restore (push / pop / swap), sticky stack error bits and a
//            16-entry branch-condition decoder.
// Ports    : clock, n_rst        - clock, asynchronous active-low reset
//            flags_in, flag_we   - ALU flag values and per-bit write enables
//            push, pop           - stack save / restore (both = swap)
//            err_clr             - clears stack_ovf / stack_unf
//            func, bre           - branch condition select and enable
//            is_br               - branch taken (combinational)
//            flag_q              - current flag register
//            stack_empty/full    - stack pointer at 0 / at STACK_DEPTH
//            stack_ovf/unf       - sticky push-while-full / pop-while-empty
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

`ifndef Z_FLAG
`define Z_FLAG 0
`endif
`ifndef N_FLAG
`define N_FLAG 1
`endif
`ifndef V_FLAG
`define V_FLAG 2
`endif
`ifndef C_FLAG
`define C_FLAG 3
`endif

module flag_stack_br_unit #(
    parameter int FLAG_W      = 4,
    parameter int STACK_DEPTH = 4,
    parameter int BYPASS      = 0
) (
    input  logic              clock,
    input  logic              n_rst,
    input  logic [FLAG_W-1:0] flags_in,
    input  logic [FLAG_W-1:0] flag_we,
    input  logic              push,
    input  logic              pop,
    input  logic              err_clr,
    input  logic [3:0]        func,
    input  logic              bre,
    output logic              is_br,
    output logic [FLAG_W-1:0] flag_q,
    output logic              stack_empty,
    output logic              stack_full,
    output logic              stack_ovf,
    output logic              stack_unf
);

    // Pointer must represent 0..STACK_DEPTH inclusive.
    localparam int SP_W = $clog2(STACK_DEPTH + 1);
    localparam logic [SP_W-1:0] c_sp_full = SP_W'(STACK_DEPTH);
    localparam logic [SP_W-1:0] c_sp_one  = SP_W'(1);

    logic [FLAG_W-1:0] flag_d;
    logic [SP_W-1:0]   sp_q, sp_d;
    logic              ovf_q, ovf_d;
    logic              unf_q, unf_d;
    logic [FLAG_W-1:0] stk_q [STACK_DEPTH];
    logic [FLAG_W-1:0] stk_d [STACK_DEPTH];

    logic              w_empty;
    logic              w_full;
    logic [SP_W-1:0]   w_top_idx;
    logic [FLAG_W-1:0] w_top;
    logic [FLAG_W-1:0] w_masked;
    logic              w_stk_we;
    logic [SP_W-1:0]   w_wr_idx;
    logic              w_z, w_n, w_v, w_c;
    logic              w_cond;

    assign w_empty  = (sp_q == '0);
    assign w_full   = (sp_q == c_sp_full);
    // Clamp to entry 0 when empty so the read mux never selects a
    // non-existent entry; the value is unused in that case.
    assign w_top_idx = w_empty ? '0 : (sp_q - c_sp_one);
    assign w_masked  = (flag_q & ~flag_we) | (flags_in & flag_we);

    always_comb begin
        w_top = '0;
        for (int i = 0; i < STACK_DEPTH; i++) begin
            if (w_top_idx == SP_W'(i)) begin
                w_top = stk_q[i];
            end
        end
    end

    // Next-state: a successful pop (alone or as swap) overrides the masked
    // write; everything else lets the masked write through.
    always_comb begin
        flag_d   = w_masked;
        sp_d     = sp_q;
        ovf_d    = ovf_q & ~err_clr;
        unf_d    = unf_q & ~err_clr;
        w_stk_we = 1'b0;
        w_wr_idx = sp_q;

        if (pop && push && !w_empty) begin
            w_stk_we = 1'b1;
            w_wr_idx = w_top_idx;
            flag_d   = w_top;
        end else if (pop && !push && !w_empty) begin
            flag_d = w_top;
            sp_d   = sp_q - c_sp_one;
        end else if (pop && !push) begin
            unf_d = 1'b1;
        end else if (push) begin
            // Covers push alone and push+pop on an empty stack.
            if (!w_full) begin
                w_stk_we = 1'b1;
                w_wr_idx = sp_q;
                sp_d     = sp_q + c_sp_one;
            end else begin
                ovf_d = 1'b1;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < STACK_DEPTH; i++) begin
            stk_d[i] = stk_q[i];
            if (w_stk_we && (w_wr_idx == SP_W'(i))) begin
                stk_d[i] = flag_q;
            end
        end
    end

    always_ff @(posedge clock or negedge n_rst) begin
        if (!n_rst) begin
            flag_q <= '0;
            sp_q   <= '0;
            ovf_q  <= 1'b0;
            unf_q  <= 1'b0;
        end else begin
            flag_q <= flag_d;
            sp_q   <= sp_d;
            ovf_q  <= ovf_d;
            unf_q  <= unf_d;
        end
    end

    // Stack contents carry no reset; only the pointer defines validity.
    always_ff @(posedge clock) begin
        stk_q <= stk_d;
    end

    assign stack_empty = w_empty;
    assign stack_full  = w_full;
    assign stack_ovf   = ovf_q;
    assign stack_unf   = unf_q;

    // Decode source: registered flags, or the forwarded next-state flags.
    assign w_z = (BYPASS != 0) ? flag_d[`Z_FLAG] : flag_q[`Z_FLAG];
    assign w_n = (BYPASS != 0) ? flag_d[`N_FLAG] : flag_q[`N_FLAG];
    assign w_v = (BYPASS != 0) ? flag_d[`V_FLAG] : flag_q[`V_FLAG];
    assign w_c = (BYPASS != 0) ? flag_d[`C_FLAG] : flag_q[`C_FLAG];

    always_comb begin
        w_cond = 1'b0;
        case (func)
            4'd0:  w_cond = 1'b1;
            4'd1:  w_cond = w_z;
            4'd2:  w_cond = ~w_z;
            4'd3:  w_cond = w_n ^ w_v;
            4'd4:  w_cond = ~(w_n ^ w_v);
            4'd5:  w_cond = w_c;
            4'd6:  w_cond = ~w_c;
            4'd7:  w_cond = w_v;
            4'd8:  w_cond = ~w_v;
            4'd9:  w_cond = w_n;
            4'd10: w_cond = ~w_n;
            4'd11: w_cond = ~w_z & ~(w_n ^ w_v);
            4'd12: w_cond = w_z | (w_n ^ w_v);
            4'd13: w_cond = ~w_c & ~w_z;
            4'd14: w_cond = w_c | w_z;
            default: w_cond = 1'b0;
        endcase
    end

    assign is_br = w_cond & bre;

endmodule

`default_nettype wire

// File: tb/tb_flag_stack_br_unit.sv
//==============================================================================
// Module   : tb_flag_stack_br_unit
// Purpose  : Self-checking bench for flag_stack_br_unit. Two instances share
//            stimulus: one registered-decode, one forwarded-decode. A queue
//            based reference model predicts every output.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

`ifndef Z_FLAG
`define Z_FLAG 0
`endif
`ifndef N_FLAG
`define N_FLAG 1
`endif
`ifndef V_FLAG
`define V_FLAG 2
`endif
`ifndef C_FLAG
`define C_FLAG 3
`endif

module tb_flag_stack_br_unit;

    localparam int FW    = 5;
    localparam int DEPTH = 4;
    localparam logic [FW-1:0] c_z = FW'(1) << `Z_FLAG;
    localparam logic [FW-1:0] c_n = FW'(1) << `N_FLAG;
    localparam logic [FW-1:0] c_v = FW'(1) << `V_FLAG;
    localparam logic [FW-1:0] c_c = FW'(1) << `C_FLAG;
    localparam logic [FW-1:0] c_all = '1;

    logic          clock = 1'b0;
    logic          n_rst;
    logic [FW-1:0] flags_in, flag_we;
    logic          push, pop, err_clr, bre;
    logic [3:0]    func;

    logic          is_br0, is_br1;
    logic [FW-1:0] flag_q0, flag_q1;
    logic          empty0, full0, ovf0, unf0;
    logic          empty1, full1, ovf1, unf1;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    logic [FW-1:0] m_flag;
    logic [FW-1:0] m_stk[$];
    logic          m_ovf, m_unf;

    always #5 clock = ~clock;

    flag_stack_br_unit #(.FLAG_W(FW), .STACK_DEPTH(DEPTH), .BYPASS(0)) u_reg (
        .clock(clock), .n_rst(n_rst), .flags_in(flags_in), .flag_we(flag_we),
        .push(push), .pop(pop), .err_clr(err_clr), .func(func), .bre(bre),
        .is_br(is_br0), .flag_q(flag_q0), .stack_empty(empty0),
        .stack_full(full0), .stack_ovf(ovf0), .stack_unf(unf0)
    );

    flag_stack_br_unit #(.FLAG_W(FW), .STACK_DEPTH(DEPTH), .BYPASS(1)) u_byp (
        .clock(clock), .n_rst(n_rst), .flags_in(flags_in), .flag_we(flag_we),
        .push(push), .pop(pop), .err_clr(err_clr), .func(func), .bre(bre),
        .is_br(is_br1), .flag_q(flag_q1), .stack_empty(empty1),
        .stack_full(full1), .stack_ovf(ovf1), .stack_unf(unf1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic cond(input logic [3:0] fn, input logic [FW-1:0] f);
        logic z, n, v, c;
        z = f[`Z_FLAG]; n = f[`N_FLAG]; v = f[`V_FLAG]; c = f[`C_FLAG];
        case (fn)
            4'd0:  return 1'b1;
            4'd1:  return z;
            4'd2:  return !z;
            4'd3:  return n != v;
            4'd4:  return n == v;
            4'd5:  return c;
            4'd6:  return !c;
            4'd7:  return v;
            4'd8:  return !v;
            4'd9:  return n;
            4'd10: return !n;
            4'd11: return !z && (n == v);
            4'd12: return z || (n != v);
            4'd13: return !c && !z;
            4'd14: return c || z;
            default: return 1'b0;
        endcase
    endfunction

    // Flags the register will hold after this cycle's edge.
    function automatic logic [FW-1:0] model_next();
        if (pop && m_stk.size() != 0) return m_stk[$];
        return (m_flag & ~flag_we) | (flags_in & flag_we);
    endfunction

    task automatic model_commit();
        logic [FW-1:0] nf;
        logic [FW-1:0] top;
        nf = model_next();
        if (err_clr) begin
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end
        if (pop && m_stk.size() != 0) begin
            top = m_stk.pop_back();
            if (push) m_stk.push_back(m_flag);
        end else if (pop && !push) begin
            m_unf = 1'b1;
        end else if (push) begin
            if (m_stk.size() < DEPTH) m_stk.push_back(m_flag);
            else m_ovf = 1'b1;
        end
        m_flag = nf;
    endtask

    task automatic model_reset();
        m_flag = '0;
        m_stk.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
    endtask

    task automatic check_state();
        chk("flag_q",      32'(flag_q0), 32'(m_flag));
        chk("flag_q_byp",  32'(flag_q1), 32'(m_flag));
        chk("stack_empty", 32'(empty0),  32'(m_stk.size() == 0));
        chk("stack_full",  32'(full0),   32'(m_stk.size() == DEPTH));
        chk("stack_ovf",   32'(ovf0),    32'(m_ovf));
        chk("stack_unf",   32'(unf0),    32'(m_unf));
    endtask

    // Drive one cycle, check outputs mid-cycle, then advance the model.
    task automatic step(input logic [FW-1:0] fi, input logic [FW-1:0] we,
                        input logic pu, input logic po, input logic ec,
                        input logic [3:0] fn, input logic b);
        flags_in = fi; flag_we = we; push = pu; pop = po;
        err_clr = ec; func = fn; bre = b;
        @(negedge clock);
        check_state();
        chk($sformatf("is_br_f%0d", fn),     32'(is_br0), 32'(cond(fn, m_flag) && b));
        chk($sformatf("is_br_byp_f%0d", fn), 32'(is_br1), 32'(cond(fn, model_next()) && b));
        @(posedge clock);
        model_commit();
        #1;
    endtask

    task automatic idle(input logic [3:0] fn);
        step('0, '0, 1'b0, 1'b0, 1'b0, fn, 1'b1);
    endtask

    initial begin
        n_rst = 1'b0;
        flags_in = '0; flag_we = '0; push = 0; pop = 0; err_clr = 0;
        func = 4'd0; bre = 1'b0;
        model_reset();
        #2;
        check_state();
        #10 n_rst = 1'b1;
        @(posedge clock); #1;

        // Always / enable gating
        idle(4'd0);
        step('0, '0, 0, 0, 0, 4'd0, 1'b0);
        idle(4'd15);

        // Full write of Z: registered vs forwarded decode
        step(c_z, c_all, 0, 0, 0, 4'd1, 1'b1);
        idle(4'd1);

        // Masked write: Z|C then clear only Z
        step(c_z | c_c, c_all, 0, 0, 0, 4'd14, 1'b1);
        step('0, c_z, 0, 0, 0, 4'd13, 1'b1);
        idle(4'd13);
        idle(4'd14);

        // Push with same-cycle write, pops and underflow
        step(c_n, c_all, 0, 0, 0, 4'd9, 1'b1);
        step(c_v, c_all, 1, 0, 0, 4'd7, 1'b1);
        step(c_c, c_all, 0, 1, 0, 4'd9, 1'b1);
        step(c_c, c_all, 0, 1, 0, 4'd9, 1'b1);
        step('0, '0, 0, 0, 1, 4'd3, 1'b1);
        idle(4'd4);

        // Fill to overflow, then drain in LIFO order
        for (int i = 0; i < 5; i++) begin
            step(FW'(i + 1), c_all, 1, 0, 0, 4'(i + 3), 1'b1);
        end
        step('0, '0, 0, 0, 1, 4'd0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            step('0, '0, 0, 1, 0, 4'(i + 9), 1'b1);
        end
        step('0, '0, 0, 0, 1, 4'd0, 1'b1);

        // Swap, push+pop on empty, error set/clear in same cycle
        step(c_c, c_all, 0, 0, 0, 4'd5, 1'b1);
        step(c_z, c_all, 1, 0, 0, 4'd1, 1'b1);
        step('0, '0, 1, 1, 0, 4'd5, 1'b1);
        step('0, '0, 0, 1, 0, 4'd1, 1'b1);
        step(c_v, c_all, 1, 1, 0, 4'd7, 1'b1);
        step('0, '0, 0, 1, 0, 4'd8, 1'b1);
        step('0, '0, 0, 1, 1, 4'd0, 1'b1);
        idle(4'd2);

        // Asynchronous reset mid-sequence
        step(c_n, c_all, 1, 0, 0, 4'd9, 1'b1);
        step('0, '0, 0, 1, 0, 4'd0, 1'b1);
        step('0, '0, 0, 1, 0, 4'd0, 1'b1);
        push = 0; pop = 0; err_clr = 0; flag_we = '0;
        #2 n_rst = 1'b0;
        #1;
        model_reset();
        check_state();
        #2 n_rst = 1'b1;
        @(posedge clock); #1;
        idle(4'd1);

        // Randomized traffic
        for (int i = 0; i < 500; i++) begin
            step(FW'($urandom), FW'($urandom),
                 $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
                 $urandom_range(0, 7) == 0, 4'($urandom), $urandom_range(0, 4) != 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
